// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC datapath: register file geometry,
// the hard-wired zero register index and the write-back select encodings.
// Imported by the register file and its scoreboard.
package kgp_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 2 ** ADDR_W;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // mem_reg_pc_selector encodings for the write-back source
  localparam logic [1:0] WB_REG = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/rf_scoreboard.sv
// Purpose: per-register outstanding-load tracker; reports busy sources and a
//   sticky error when a load completes into a register that was not pending.
// Ports: ld_issue/ld_addr set, we&ld_done/wr_addr clear, rs/rt_addr lookups
//   (combinational rs_busy/rt_busy), sb_err registered and sticky until rst.
module rf_scoreboard
  import kgp_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int NREG_P   = NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W_P-1:0] wr_addr,
  input  logic              ld_done,
  input  logic              ld_issue,
  input  logic [ADDR_W_P-1:0] ld_addr,
  input  logic [ADDR_W_P-1:0] rs_addr,
  input  logic [ADDR_W_P-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic              sb_err
);

  logic [NREG_P-1:0] busy_q, busy_d;
  logic              sb_err_q, sb_err_d;
  logic              ld_cmpl;

  assign ld_cmpl = we & ld_done;

  always_comb begin
    busy_d   = busy_q;
    sb_err_d = sb_err_q;
    if (ld_cmpl) begin
      busy_d[wr_addr] = 1'b0;
      if ((wr_addr != '0) && !busy_q[wr_addr]) sb_err_d = 1'b1;
    end
    // Applied after the clear so a new load to the same register wins.
    if (ld_issue && (ld_addr != '0)) busy_d[ld_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  // A completing load is bypassed to the reader, so it does not stall.
  assign rs_busy = (rs_addr != '0) && busy_q[rs_addr] && !(ld_cmpl && (wr_addr == rs_addr));
  assign rt_busy = (rt_addr != '0) && busy_q[rt_addr] && !(ld_cmpl && (wr_addr == rt_addr));
  assign sb_err  = sb_err_q;

endmodule

// File: rtl/reg_file_wb.sv
// Purpose: KGP-RISC write-back register file, 32 x 32, r0 hard-wired to 0.
// Ports: we/wr_addr/write_data write port (1 edge to array, same-cycle
//   bypass to reads); rs/rt combinational reads; load scoreboard drives
//   rs_busy/rt_busy/stall (combinational) and sticky sb_err.
module reg_file_wb
  import kgp_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int NREG_P   = NREG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDR_W_P-1:0] wr_addr,
  input  logic [DATA_W_P-1:0] write_data,
  input  logic                ld_done,
  input  logic                ld_issue,
  input  logic [ADDR_W_P-1:0] ld_addr,
  input  logic [ADDR_W_P-1:0] rs_addr,
  input  logic [ADDR_W_P-1:0] rt_addr,
  output logic [DATA_W_P-1:0] rs_data,
  output logic [DATA_W_P-1:0] rt_data,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic                stall,
  output logic                sb_err
);

  logic [DATA_W_P-1:0] regs_q [NREG_P];
  logic [DATA_W_P-1:0] regs_d [NREG_P];

  always_comb begin
    regs_d = regs_q;
    if (we && (wr_addr != '0)) regs_d[wr_addr] = write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  function automatic logic [DATA_W_P-1:0] rd_port(input logic [ADDR_W_P-1:0] addr);
    if (addr == '0)                  return '0;
    else if (we && (wr_addr == addr)) return write_data;
    else                             return regs_q[addr];
  endfunction

  assign rs_data = rd_port(rs_addr);
  assign rt_data = rd_port(rt_addr);

  rf_scoreboard #(
    .ADDR_W_P (ADDR_W_P),
    .NREG_P   (NREG_P)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wr_addr  (wr_addr),
    .ld_done  (ld_done),
    .ld_issue (ld_issue),
    .ld_addr  (ld_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .sb_err   (sb_err)
  );

  assign stall = rs_busy | rt_busy;

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

  logic        clk, rst;
  logic        we, ld_done, ld_issue;
  logic [4:0]  wr_addr, ld_addr, rs_addr, rt_addr;
  logic [31:0] write_data, rs_data, rt_data;
  logic        rs_busy, rt_busy, stall, sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_wb dut (
    .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .write_data(write_data),
    .ld_done(ld_done), .ld_issue(ld_issue), .ld_addr(ld_addr),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .stall(stall), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; ld_done = 0; ld_issue = 0;
    wr_addr = 0; ld_addr = 0; write_data = 0;
  endtask

  initial begin
    idle();
    rs_addr = 0; rt_addr = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;

    // Reset state
    rs_addr = 5; rt_addr = 7; #1;
    chk("rst_rs_data", rs_data, 32'h0);
    chk("rst_rt_data", rt_data, 32'h0);
    chk("rst_stall",   {31'b0, stall}, 32'h0);
    chk("rst_sb_err",  {31'b0, sb_err}, 32'h0);

    // Write r5 with same-cycle bypass, then from the array
    tick();
    we = 1; wr_addr = 5; write_data = 32'hDEADBEEF; rs_addr = 5; #1;
    chk("wr_bypass", rs_data, 32'hDEADBEEF);
    tick();
    idle(); #1;
    chk("wr_array", rs_data, 32'hDEADBEEF);

    // Write to r0 is discarded
    we = 1; wr_addr = 0; write_data = 32'h1234; rs_addr = 0; rt_addr = 5; #1;
    chk("r0_bypass", rs_data, 32'h0);
    chk("rt_r5", rt_data, 32'hDEADBEEF);
    tick();
    idle(); #1;
    chk("r0_array", rs_data, 32'h0);

    // Load stall on r7
    ld_issue = 1; ld_addr = 7; rt_addr = 7; #1;
    chk("ld_own_cycle", {31'b0, rt_busy}, 32'h0);
    tick();
    idle(); #1;
    chk("ld_rt_busy1", {31'b0, rt_busy}, 32'h1);
    chk("ld_stall1",   {31'b0, stall}, 32'h1);
    tick();
    chk("ld_stall2",   {31'b0, stall}, 32'h1);
    we = 1; ld_done = 1; wr_addr = 7; write_data = 32'hA5A5A5A5; #1;
    chk("ld_cmpl_stall", {31'b0, stall}, 32'h0);
    chk("ld_cmpl_data",  rt_data, 32'hA5A5A5A5);
    tick();
    idle(); #1;
    chk("ld_after_busy", {31'b0, rt_busy}, 32'h0);
    chk("ld_after_data", rt_data, 32'hA5A5A5A5);
    chk("ld_no_err",     {31'b0, sb_err}, 32'h0);

    // Simultaneous complete and reissue of r9: set wins
    ld_issue = 1; ld_addr = 9; rt_addr = 0;
    tick();
    idle();
    we = 1; ld_done = 1; wr_addr = 9; write_data = 32'h9; ld_issue = 1; ld_addr = 9;
    tick();
    idle(); rs_addr = 9; #1;
    chk("setclr_busy", {31'b0, rs_busy}, 32'h1);
    chk("setclr_err",  {31'b0, sb_err}, 32'h0);
    we = 1; ld_done = 1; wr_addr = 9; write_data = 32'h99;
    tick();
    idle(); #1;
    chk("r9_clear", {31'b0, rs_busy}, 32'h0);
    chk("r9_data",  rs_data, 32'h99);

    // Non-load write to busy r3 keeps it busy; load result lands last
    ld_issue = 1; ld_addr = 3;
    tick();
    idle();
    we = 1; wr_addr = 3; write_data = 32'h33; rs_addr = 3; #1;
    chk("nl_busy_byp", {31'b0, rs_busy}, 32'h1);
    chk("nl_data_byp", rs_data, 32'h33);
    tick();
    idle(); #1;
    chk("nl_busy", {31'b0, rs_busy}, 32'h1);
    chk("nl_data", rs_data, 32'h33);
    we = 1; ld_done = 1; wr_addr = 3; write_data = 32'h44;
    tick();
    idle(); #1;
    chk("r3_ld_data", rs_data, 32'h44);
    chk("r3_ld_busy", {31'b0, rs_busy}, 32'h0);
    chk("r3_no_err",  {31'b0, sb_err}, 32'h0);

    // Completion into non-busy r12 sets sticky error
    we = 1; ld_done = 1; wr_addr = 12; write_data = 32'hC; #1;
    chk("err_pre_edge", {31'b0, sb_err}, 32'h0);
    tick();
    idle(); #1;
    chk("err_set", {31'b0, sb_err}, 32'h1);
    tick();
    chk("err_held", {31'b0, sb_err}, 32'h1);

    // Async reset mid-cycle drops an outstanding load on r7
    ld_issue = 1; ld_addr = 7;
    tick();
    idle(); rs_addr = 5; rt_addr = 7; #1;
    chk("pre_rst_busy", {31'b0, rt_busy}, 32'h1);
    chk("pre_rst_data", rs_data, 32'hDEADBEEF);
    #2 rst = 1; #1;
    chk("arst_rs_data", rs_data, 32'h0);
    chk("arst_rt_data", rt_data, 32'h0);
    chk("arst_stall",   {31'b0, stall}, 32'h0);
    chk("arst_sb_err",  {31'b0, sb_err}, 32'h0);
    #1 rst = 0;
    tick();
    we = 1; ld_done = 1; wr_addr = 7; write_data = 32'h77;
    tick();
    idle(); #1;
    chk("orphan_err", {31'b0, sb_err}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
